// File: rtl/decode_stage_pkg.sv
// Shared constants, the D pipeline-register layout and the register-ID
// derivation helpers used by the decode stage.
package decode_stage_pkg;

   localparam int unsigned WORD_W = 64;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Register IDs
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   // Status codes
   localparam logic [3:0] SAOK = 4'h1;
   localparam logic [3:0] SADR = 4'h2;
   localparam logic [3:0] SINS = 4'h3;
   localparam logic [3:0] SHLT = 4'h4;

   typedef struct packed {
      logic [3:0]        icode;
      logic [3:0]        ifun;
      logic [3:0]        ra;
      logic [3:0]        rb;
      logic [WORD_W-1:0] valc;
      logic [WORD_W-1:0] valp;
      logic [3:0]        stat;
   } dreg_t;

   localparam dreg_t DREG_BUBBLE = '{
      icode: INOP,
      ifun:  4'h0,
      ra:    RNONE,
      rb:    RNONE,
      valc:  '0,
      valp:  '0,
      stat:  SAOK
   };

   function automatic logic [3:0] get_src_a(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: get_src_a = ra;
         IPOPQ, IRET:                    get_src_a = RRSP;
         default:                        get_src_a = RNONE;
      endcase
   endfunction

   function automatic logic [3:0] get_src_b(input logic [3:0] icode, input logic [3:0] rb);
      case (icode)
         IOPQ, IRMMOVQ, IMRMOVQ:      get_src_b = rb;
         IPUSHQ, IPOPQ, ICALL, IRET:  get_src_b = RRSP;
         default:                     get_src_b = RNONE;
      endcase
   endfunction

   // CMOV condition is resolved in execute; decode always names rB.
   function automatic logic [3:0] get_dst_e(input logic [3:0] icode, input logic [3:0] rb);
      case (icode)
         IRRMOVQ, IIRMOVQ, IOPQ:      get_dst_e = rb;
         IPUSHQ, IPOPQ, ICALL, IRET:  get_dst_e = RRSP;
         default:                     get_dst_e = RNONE;
      endcase
   endfunction

   function automatic logic [3:0] get_dst_m(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         IMRMOVQ, IPOPQ: get_dst_m = ra;
         default:        get_dst_m = RNONE;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch inputs, pipeline control, forwarding sources and decode
// results exchanged between the decode stage and the rest of the pipeline.
interface decode_stage_if;
   import decode_stage_pkg::*;

   logic [3:0]        f_icode_i;
   logic [3:0]        f_ifun_i;
   logic [3:0]        f_rA_i;
   logic [3:0]        f_rB_i;
   logic [WORD_W-1:0] f_valC_i;
   logic [WORD_W-1:0] f_valP_i;
   logic [3:0]        f_stat_i;
   logic              D_stall_i;
   logic              D_bubble_i;
   logic [3:0]        e_dstE_i;
   logic [WORD_W-1:0] e_valE_i;
   logic [3:0]        M_dstM_i;
   logic [WORD_W-1:0] m_valM_i;
   logic [3:0]        M_dstE_i;
   logic [WORD_W-1:0] M_valE_i;
   logic [3:0]        W_dstM_i;
   logic [WORD_W-1:0] W_valM_i;
   logic [3:0]        W_dstE_i;
   logic [WORD_W-1:0] W_valE_i;

   logic [3:0]        D_icode_o;
   logic [3:0]        d_icode_o;
   logic [3:0]        d_ifun_o;
   logic [3:0]        d_stat_o;
   logic [WORD_W-1:0] d_valC_o;
   logic [3:0]        d_srcA_o;
   logic [3:0]        d_srcB_o;
   logic [3:0]        d_dstE_o;
   logic [3:0]        d_dstM_o;
   logic [WORD_W-1:0] d_valA_o;
   logic [WORD_W-1:0] d_valB_o;

   modport master (
      output f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_valC_i, f_valP_i, f_stat_i,
      output D_stall_i, D_bubble_i,
      output e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
      output W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
      input  D_icode_o, d_icode_o, d_ifun_o, d_stat_o, d_valC_o,
      input  d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o
   );

   modport slave (
      input  f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_valC_i, f_valP_i, f_stat_i,
      input  D_stall_i, D_bubble_i,
      input  e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
      input  W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
      output D_icode_o, d_icode_o, d_ifun_o, d_stat_o, d_valC_o,
      output d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o
   );

endinterface

// File: rtl/y86_regfile.sv
// Architectural register file: NREG x 64-bit, two asynchronous read ports,
// two write ports with port M taking priority on a shared destination.
module y86_regfile
   import decode_stage_pkg::*;
#(
   parameter int unsigned NREG = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        src_a,
   input  logic [3:0]        src_b,
   output logic [WORD_W-1:0] val_a,
   output logic [WORD_W-1:0] val_b,
   input  logic [3:0]        dst_e,
   input  logic [WORD_W-1:0] val_e,
   input  logic [3:0]        dst_m,
   input  logic [WORD_W-1:0] val_m
);

   logic [WORD_W-1:0] regs_q [NREG];

   logic we_e;
   logic we_m;

   assign we_e = (dst_e != RNONE) && (32'(dst_e) < NREG);
   assign we_m = (dst_m != RNONE) && (32'(dst_m) < NREG);

   // Clear on reset; port M is written last so it wins a shared destination.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (we_e) begin
            regs_q[dst_e] <= val_e;
         end
         if (we_m) begin
            regs_q[dst_m] <= val_m;
         end
      end
   end

   // Asynchronous reads; IDs outside the file (incl. RNONE) read as zero.
   always_comb begin
      val_a = '0;
      val_b = '0;
      if (32'(src_a) < NREG) begin
         val_a = regs_q[src_a];
      end
      if (32'(src_b) < NREG) begin
         val_b = regs_q[src_b];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register-ID derivation, register
// file access and forwarding of valA/valB from later stages.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned NREG = 15
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);

   dreg_t dreg_q;

   logic [3:0]        src_a;
   logic [3:0]        src_b;
   logic [WORD_W-1:0] rf_val_a;
   logic [WORD_W-1:0] rf_val_b;
   logic [WORD_W-1:0] val_a;
   logic [WORD_W-1:0] val_b;

   // D register: reset and bubble load a NOP; stall outranks bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dreg_q <= DREG_BUBBLE;
      end else if (bus.D_stall_i) begin
         dreg_q <= dreg_q;
      end else if (bus.D_bubble_i) begin
         dreg_q <= DREG_BUBBLE;
      end else begin
         dreg_q <= '{
            icode: bus.f_icode_i,
            ifun:  bus.f_ifun_i,
            ra:    bus.f_rA_i,
            rb:    bus.f_rB_i,
            valc:  bus.f_valC_i,
            valp:  bus.f_valP_i,
            stat:  bus.f_stat_i
         };
      end
   end

   assign src_a = get_src_a(dreg_q.icode, dreg_q.ra);
   assign src_b = get_src_b(dreg_q.icode, dreg_q.rb);

   y86_regfile #(
      .NREG (NREG)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .src_a (src_a),
      .src_b (src_b),
      .val_a (rf_val_a),
      .val_b (rf_val_b),
      .dst_e (bus.W_dstE_i),
      .val_e (bus.W_valE_i),
      .dst_m (bus.W_dstM_i),
      .val_m (bus.W_valM_i)
   );

   // valA: valP for call/jXX, else youngest-first forwarding, else register file.
   always_comb begin
      val_a = '0;
      if (dreg_q.icode == ICALL || dreg_q.icode == IJXX) begin
         val_a = dreg_q.valp;
      end else if (src_a == RNONE) begin
         val_a = '0;
      end else if (src_a == bus.e_dstE_i) begin
         val_a = bus.e_valE_i;
      end else if (src_a == bus.M_dstM_i) begin
         val_a = bus.m_valM_i;
      end else if (src_a == bus.M_dstE_i) begin
         val_a = bus.M_valE_i;
      end else if (src_a == bus.W_dstM_i) begin
         val_a = bus.W_valM_i;
      end else if (src_a == bus.W_dstE_i) begin
         val_a = bus.W_valE_i;
      end else begin
         val_a = rf_val_a;
      end
   end

   // valB: same forwarding chain keyed on srcB, no valP path.
   always_comb begin
      val_b = '0;
      if (src_b == RNONE) begin
         val_b = '0;
      end else if (src_b == bus.e_dstE_i) begin
         val_b = bus.e_valE_i;
      end else if (src_b == bus.M_dstM_i) begin
         val_b = bus.m_valM_i;
      end else if (src_b == bus.M_dstE_i) begin
         val_b = bus.M_valE_i;
      end else if (src_b == bus.W_dstM_i) begin
         val_b = bus.W_valM_i;
      end else if (src_b == bus.W_dstE_i) begin
         val_b = bus.W_valE_i;
      end else begin
         val_b = rf_val_b;
      end
   end

   assign bus.D_icode_o = dreg_q.icode;
   assign bus.d_icode_o = dreg_q.icode;
   assign bus.d_ifun_o  = dreg_q.ifun;
   assign bus.d_stat_o  = dreg_q.stat;
   assign bus.d_valC_o  = dreg_q.valc;
   assign bus.d_srcA_o  = src_a;
   assign bus.d_srcB_o  = src_b;
   assign bus.d_dstE_o  = get_dst_e(dreg_q.icode, dreg_q.rb);
   assign bus.d_dstM_o  = get_dst_m(dreg_q.icode, dreg_q.ra);
   assign bus.d_valA_o  = val_a;
   assign bus.d_valB_o  = val_b;

endmodule
